// File: rtl/bus_master_program_sequencer_pkg.sv
// Shared encodings for the program sequencer: bus status, burst/size codes,
// program markers and FSM states.
package bus_master_program_sequencer_pkg;

  localparam logic [1:0] S_START = 2'b00;
  localparam logic [1:0] S_CONT  = 2'b01;
  localparam logic [1:0] S_IDLE  = 2'b10;
  localparam logic [1:0] S_BUSY  = 2'b11;

  localparam logic [3:0] BURST1    = 4'd0;
  localparam logic [3:0] BURST2    = 4'd1;
  localparam logic [3:0] BURST4    = 4'd2;
  localparam logic [3:0] BURST8    = 4'd3;
  localparam logic [3:0] BURST16   = 4'd4;
  localparam logic [3:0] BURST32   = 4'd5;
  localparam logic [3:0] BURST64   = 4'd6;
  localparam logic [3:0] BURSTPAGE = 4'd7;

  localparam logic [1:0] SIZE_B  = 2'd0;
  localparam logic [1:0] SIZE_HW = 2'd1;
  localparam logic [1:0] SIZE_W  = 2'd2;
  localparam logic [1:0] SIZE_DW = 2'd3;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [31:0] PROGRAM_ADDRESS_SEQUENCE = 32'h3FFF_FFFF;
  localparam logic [6:0]  PROG_TERMINATOR          = 7'h7F;

  typedef struct packed {
    logic [3:0] burst;
    logic [1:0] size;
    logic       we;
  } ctl_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Page bursts (and unused codes) are issued as a single beat.
  function automatic logic [7:0] burst_beats(input logic [3:0] b);
    if (b <= BURST64) return 8'd1 << b;
    else              return 8'd1;
  endfunction

endpackage

// File: rtl/bus_master_program_sequencer_if.sv
// Master-side bus to the arbiter/mux: request/grant handshake plus beat signals.
interface bus_master_program_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              ack;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [8:0]        control;

  modport master (output req, address, wdata, control, input ack, ready, rdata);
  modport slave  (input req, address, wdata, control, output ack, ready, rdata);
endinterface

// File: rtl/bus_master_program_sequencer_prog_store.sv
// Program entry store: synchronous write, combinational read. No reset on contents.
module bus_master_program_sequencer_prog_store #(
  parameter int DEPTH = 64,
  parameter int W     = 71,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/bus_master_program_sequencer.sv
// Captures a program of bus entries, then replays them as bursts on trigger,
// honouring arbiter grant at transaction boundaries and slave wait states.
module bus_master_program_sequencer
  import bus_master_program_sequencer_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_prog,
  input  logic [ADDR_W-1:0] i_progaddress,
  input  logic [DATA_W-1:0] i_progdata,
  input  logic [6:0]        i_progcontrol,
  input  logic              i_trigger,
  bus_master_program_sequencer_if.master bus,
  output logic [DATA_W-1:0] o_rdata_out,
  output logic              o_rdata_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;   // one extra bit so a full store (== DEPTH) is representable
  localparam int EW = ADDR_W + DATA_W + 7;

  state_t            r_state, w_next;
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_len;
  logic [7:0]        r_beat;
  logic              r_prog_d, r_term, r_overflow, r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic [EW-1:0]     w_rd_entry;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  ctl_t              w_ctl;
  logic [PW-1:0]     w_eff_ptr;
  logic              w_rise, w_is_term, w_prog_en, w_we, w_full;
  logic              w_issue, w_adv, w_last_beat, w_last_entry;

  assign w_rise    = i_prog && !r_prog_d;
  assign w_is_term = (i_progcontrol == PROG_TERMINATOR);
  assign w_prog_en = i_prog && (r_state == ST_IDLE) && !(r_term && !w_rise);
  assign w_eff_ptr = w_rise ? '0 : r_wr_ptr;
  assign w_full    = (w_eff_ptr == PW'(DEPTH));
  assign w_we      = w_prog_en && !w_is_term && !w_full;

  bus_master_program_sequencer_prog_store #(.DEPTH(DEPTH), .W(EW)) u_store (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_eff_ptr[AW-1:0]),
    .i_wdata ({i_progaddress, i_progdata, i_progcontrol}),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_entry)
  );

  assign w_addr = w_rd_entry[EW-1 -: ADDR_W];
  assign w_data = w_rd_entry[7 +: DATA_W];
  assign w_ctl  = ctl_t'(w_rd_entry[6:0]);

  assign w_issue      = (r_state == ST_ISSUE);
  assign w_adv        = w_issue && bus.ready;
  assign w_last_beat  = (r_beat + 8'd1 == burst_beats(w_ctl.burst));
  assign w_last_entry = (r_rd_ptr + PW'(1) == r_len);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_trigger && !i_prog) w_next = (r_len != '0) ? ST_REQ : ST_FIN;
      ST_REQ:   if (bus.ack) w_next = ST_ISSUE;
      ST_ISSUE: if (w_adv) begin
                  if (w_last_entry)               w_next = ST_FIN;
                  else if (w_last_beat && !bus.ack) w_next = ST_REQ;
                end
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_len      <= '0;
      r_rd_ptr   <= '0;
      r_beat     <= '0;
      r_prog_d   <= 1'b0;
      r_term     <= 1'b0;
      r_overflow <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_prog_d <= i_prog;
      r_rvalid <= 1'b0;
      if (!i_prog) r_term <= 1'b0;
      if (w_prog_en) begin
        if (w_rise) begin
          r_wr_ptr <= '0;
          r_len    <= '0;
        end
        if (w_is_term)   r_term     <= 1'b1;
        else if (w_full) r_overflow <= 1'b1;
        else begin
          r_wr_ptr <= w_eff_ptr + PW'(1);
          r_len    <= w_eff_ptr + PW'(1);
        end
      end
      if (r_state == ST_IDLE && i_trigger && !i_prog) begin
        r_rd_ptr <= '0;
        r_beat   <= '0;
      end
      if (w_adv) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_beat   <= w_last_beat ? 8'd0 : r_beat + 8'd1;
        if (w_ctl.we == READ) begin
          r_rdata  <= bus.rdata;
          r_rvalid <= 1'b1;
        end
      end
    end
  end

  assign bus.req     = (r_state == ST_REQ) || w_issue;
  assign bus.address = w_issue ? w_addr : '0;
  assign bus.wdata   = w_issue ? w_data : '0;
  assign bus.control = w_issue ? {((r_beat == 8'd0) ? S_START : S_CONT), w_ctl}
                               : {S_IDLE, 7'b0};

  assign o_rdata_out   = r_rdata;
  assign o_rdata_valid = r_rvalid;
  assign o_busy        = (r_state != ST_IDLE);
  assign o_done        = (r_state == ST_FIN);
  assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_bus_master_program_sequencer.sv
// Directed bench for the program sequencer: programming, replay, wait states,
// grant delay, overflow and mid-replay reset.
module tb_bus_master_program_sequencer;
  import bus_master_program_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset, prog, trigger;
  logic [31:0] progaddress, progdata;
  logic [6:0]  progcontrol;
  logic [31:0] rdata_out;
  logic        rdata_valid, busy, done, overflow;
  int          n_chk = 0, n_bad = 0;

  bus_master_program_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_master_program_sequencer #(.DEPTH(64), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk(clk), .i_reset(reset), .i_prog(prog), .i_progaddress(progaddress),
    .i_progdata(progdata), .i_progcontrol(progcontrol), .i_trigger(trigger),
    .bus(bus), .o_rdata_out(rdata_out), .o_rdata_valid(rdata_valid),
    .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic prog_entry(input logic [31:0] a, input logic [31:0] d, input logic [6:0] c);
    prog = 1'b1; progaddress = a; progdata = d; progcontrol = c;
    tick();
  endtask

  task automatic prog_end();
    prog_entry(32'h0, 32'h0, PROG_TERMINATOR);
    prog = 1'b0; progcontrol = 7'h0;
    tick();
  endtask

  task automatic fire();
    trigger = 1'b1; tick(); trigger = 1'b0;
  endtask

  localparam logic [6:0] C_B4W_WR = {BURST4, SIZE_W, WRITE};   // 7'h15
  localparam logic [6:0] C_B4W_RD = {BURST4, SIZE_W, READ};    // 7'h14
  localparam logic [6:0] C_B1W_WR = {BURST1, SIZE_W, WRITE};   // 7'h05
  localparam logic [6:0] C_B8H_WR = {BURST8, SIZE_HW, WRITE};  // 7'h1B

  logic [31:0] d1 [4] = '{32'h11223344, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    int rdy [6] = '{1, 1, 0, 0, 1, 1};
    int bix [6] = '{0, 1, 2, 2, 2, 3};
    int nv, nb;
    logic prev_rdy, done_seen;
    logic [31:0] prev_rd, last_a;

    reset = 1'b1; prog = 0; trigger = 0; progaddress = 0; progdata = 0; progcontrol = 0;
    bus.ack = 0; bus.ready = 0; bus.rdata = 0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_control", bus.control, 9'h100);
    chk("rst_req", bus.req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_addr", bus.address, 0);

    // 1: BURST4 word write
    for (int k = 0; k < 4; k++) prog_entry(32'h4AD0, d1[k], C_B4W_WR);
    prog_end();
    bus.ack = 1; bus.ready = 1;
    fire();
    chk("t1_req", bus.req, 1);
    chk("t1_reqctl", bus.control, 9'h100);
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t1_ctl", bus.control, {(k == 0) ? S_START : S_CONT, C_B4W_WR});
      chk("t1_wdata", bus.wdata, d1[k]);
      chk("t1_addr", bus.address, 32'h4AD0);
      tick();
    end
    chk("t1_done", done, 1);
    chk("t1_req_off", bus.req, 0);
    chk("t1_fin_ctl", bus.control, 9'h100);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle", busy, 0);

    // 2: BURST4 read with wait states on beat index 2
    for (int k = 0; k < 4; k++) prog_entry(32'h14AD0, 32'h0, C_B4W_RD);
    prog_end();
    fire();
    tick();
    nv = 0; prev_rdy = 0; prev_rd = 0;
    for (int c = 0; c < 6; c++) begin
      bus.ready = rdy[c][0];
      bus.rdata = 32'hA000_0000 + bix[c];
      chk("t2_ctl", bus.control, {(bix[c] == 0) ? S_START : S_CONT, C_B4W_RD});
      chk("t2_addr", bus.address, 32'h14AD0);
      chk("t2_rvalid", rdata_valid, prev_rdy);
      if (prev_rdy) chk("t2_rdata", rdata_out, prev_rd);
      if (rdata_valid) nv++;
      prev_rdy = rdy[c][0]; prev_rd = bus.rdata;
      tick();
    end
    chk("t2_rvalid_last", rdata_valid, 1);
    chk("t2_rdata_last", rdata_out, 32'hA000_0003);
    nv++;
    chk("t2_nvalid", nv, 4);
    chk("t2_done", done, 1);
    tick();
    chk("t2_rvalid_off", rdata_valid, 0);

    // 3: register-program entry then BURST8 half-word write
    prog_entry(PROGRAM_ADDRESS_SEQUENCE, 32'h0504053A, C_B1W_WR);
    for (int k = 0; k < 8; k++) prog_entry(32'h2000 + 2 * k, 32'h100 + k, C_B8H_WR);
    prog_end();
    fire();
    tick();
    chk("t3_reg_ctl", bus.control, {S_START, C_B1W_WR});
    chk("t3_reg_addr", bus.address, 32'h3FFF_FFFF);
    chk("t3_reg_data", bus.wdata, 32'h0504053A);
    tick();
    for (int k = 0; k < 8; k++) begin
      chk("t3_ctl", bus.control, {(k == 0) ? S_START : S_CONT, C_B8H_WR});
      chk("t3_addr", bus.address, 32'h2000 + 2 * k);
      tick();
    end
    chk("t3_done", done, 1);
    tick();

    // 4: overflow, DEPTH+2 entries
    for (int k = 0; k < 66; k++) prog_entry(k, k, C_B1W_WR);
    prog_end();
    chk("t4_ovf", overflow, 1);
    fire();
    nb = 0; done_seen = 0; last_a = 0;
    for (int c = 0; c < 300 && !done_seen; c++) begin
      if (done) done_seen = 1;
      else begin
        if (bus.req && bus.control[8:7] != S_IDLE && bus.ready) begin
          nb++; last_a = bus.address;
        end
        tick();
      end
    end
    chk("t4_done_seen", done_seen, 1);
    chk("t4_beats", nb, 64);
    chk("t4_last_addr", last_a, 63);
    tick();

    // 5: grant withheld for 5 cycles
    prog_entry(32'h55, 32'h66, C_B1W_WR);
    prog_end();
    bus.ack = 0;
    fire();
    for (int c = 0; c < 5; c++) begin
      chk("t5_req", bus.req, 1);
      chk("t5_status", bus.control[8:7], S_IDLE);
      tick();
    end
    bus.ack = 1;
    chk("t5_still_req", bus.control, 9'h100);
    tick();
    chk("t5_first", bus.control, {S_START, C_B1W_WR});
    chk("t5_addr", bus.address, 32'h55);
    tick();
    chk("t5_done", done, 1);
    tick();

    // 6: reset during beat 3 of 4
    for (int k = 0; k < 4; k++) prog_entry(32'h4AD0, d1[k], C_B4W_WR);
    prog_end();
    fire();
    tick(); tick(); tick();
    chk("t6_beat3", bus.wdata, d1[2]);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_req", bus.req, 0);
    chk("t6_ctl", bus.control, 9'h100);
    chk("t6_busy", busy, 0);
    chk("t6_ovf", overflow, 0);
    tick();
    fire();
    chk("t6_done", done, 1);
    chk("t6_noreq", bus.req, 0);
    tick();
    chk("t6_done_off", done, 0);
    chk("t6_idle_req", bus.req, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
